// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period (rise to rise) of i_pwm in i_clk
// cycles, and reports a stuck line with a single timeout strobe.
module pwm_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CW          = 10,
  parameter int unsigned TIMEOUT     = 512
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_pwm,
  output logic [CW-1:0] o_high,
  output logic [CW-1:0] o_period,
  output logic          o_valid,
  output logic          o_timeout,
  output logic          o_level
);

  localparam logic [CW-1:0] TO  = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {S_IDLE, S_MEAS} state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                 s, s_d, rise;
  logic [CW-1:0]        period_cnt, period_nxt;
  logic [CW-1:0]        high_cnt, high_nxt;
  logic                 timeout_done, done_nxt;
  logic [CW-1:0]        o_high_nxt, o_period_nxt;
  logic                 o_valid_nxt, o_timeout_nxt, o_level_nxt;
  logic                 to_update;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync         <= '0;
      s_d          <= 1'b0;
      state        <= S_IDLE;
      period_cnt   <= '0;
      high_cnt     <= '0;
      timeout_done <= 1'b0;
      o_high       <= '0;
      o_period     <= '0;
      o_valid      <= 1'b0;
      o_timeout    <= 1'b0;
      o_level      <= 1'b0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], i_pwm};
      s_d          <= s;
      state        <= state_nxt;
      period_cnt   <= period_nxt;
      high_cnt     <= high_nxt;
      timeout_done <= done_nxt;
      o_high       <= o_high_nxt;
      o_period     <= o_period_nxt;
      o_valid      <= o_valid_nxt;
      o_timeout    <= o_timeout_nxt;
      o_level      <= o_level_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    period_nxt    = period_cnt;
    high_nxt      = high_cnt;
    done_nxt      = timeout_done;
    o_high_nxt    = o_high;
    o_period_nxt  = o_period;
    o_valid_nxt   = 1'b0;
    o_timeout_nxt = o_timeout;
    o_level_nxt   = o_level;
    to_update     = 1'b0;

    case (state)
      S_IDLE: begin
        if (rise) begin
          period_nxt = ONE;
          high_nxt   = ONE;
          done_nxt   = 1'b0;
          state_nxt  = S_MEAS;
        end else if (period_cnt == TO) begin
          to_update = !timeout_done;
        end else begin
          period_nxt = period_cnt + ONE;
        end
      end
      S_MEAS: begin
        if (rise) begin
          o_period_nxt  = period_cnt;
          o_high_nxt    = high_cnt;
          o_timeout_nxt = 1'b0;
          o_level_nxt   = 1'b1;
          o_valid_nxt   = 1'b1;
          period_nxt    = ONE;
          high_nxt      = ONE;
        end else if (period_cnt == TO) begin
          to_update = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          period_nxt = period_cnt + ONE;
          high_nxt   = high_cnt + {{(CW-1){1'b0}}, s};
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Marking the timeout as done on the MEAS->IDLE path too keeps IDLE
    // from firing a second strobe on the very next cycle.
    if (to_update) begin
      o_period_nxt  = '0;
      o_high_nxt    = '0;
      o_timeout_nxt = 1'b1;
      o_level_nxt   = s;
      o_valid_nxt   = 1'b1;
      done_nxt      = 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of steady PWM patterns plus hand-built
// timeout, stuck-high, 512/513 spacing and mid-period reset sequences.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CW = 10;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b1;
  logic          i_pwm = 1'b0;
  logic [CW-1:0] o_high, o_period;
  logic          o_valid, o_timeout, o_level;

  int nvec = 0;
  int nerr = 0;
  int strobe_cnt = 0;
  int last_high = 0, last_period = 0, last_timeout = 0, last_level = 0;
  logic prev_valid = 1'b0;

  pwm_capture #(.SYNC_STAGES(2), .CW(CW), .TIMEOUT(512)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_pwm     (i_pwm),
    .o_high    (o_high),
    .o_period  (o_period),
    .o_valid   (o_valid),
    .o_timeout (o_timeout),
    .o_level   (o_level)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Strobe monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_valid) begin
      strobe_cnt++;
      last_high    = int'(o_high);
      last_period  = int'(o_period);
      last_timeout = int'(o_timeout);
      last_level   = int'(o_level);
      nvec++;
      if (prev_valid) begin
        nerr++;
        $display("FAIL back_to_back_valid: got 1 expected 0 at %0t", $time);
      end
    end
    prev_valid = o_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_pwm     = 1'b0;
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    strobe_cnt = 0;
    i_reset_n  = 1'b1;
    repeat (3) @(negedge i_clk);
  endtask

  // Called at a falling edge; returns at the falling edge ending the period.
  task automatic pulse(input int high, input int period);
    i_pwm = 1'b1;
    repeat (high) @(negedge i_clk);
    i_pwm = 1'b0;
    repeat (period - high) @(negedge i_clk);
  endtask

  typedef struct {
    string name;
    int    high;
    int    period;
    int    nper;
    int    exp_strobes;
    int    exp_high;
    int    exp_period;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{"duty_0x40", 64,  256, 3, 2, 64,  256};
    vt[1] = '{"duty_0xFF", 255, 256, 3, 2, 255, 256};
    vt[2] = '{"duty_0x01", 1,   256, 3, 2, 1,   256};
    vt[3] = '{"duty_0x80", 128, 256, 4, 3, 128, 256};
    vt[4] = '{"short_20",  10,  20,  5, 4, 10,  20};
    vt[5] = '{"period_512",100, 512, 3, 2, 100, 512};

    // Reset state, checked asynchronously.
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_high",    int'(o_high),    0);
    check("rst_period",  int'(o_period),  0);
    check("rst_valid",   int'(o_valid),   0);
    check("rst_timeout", int'(o_timeout), 0);
    check("rst_level",   int'(o_level),   0);
    @(negedge i_clk);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int p = 0; p < vt[v].nper; p++) pulse(vt[v].high, vt[v].period);
      check({vt[v].name, "_strobes"}, strobe_cnt,   vt[v].exp_strobes);
      check({vt[v].name, "_high"},    last_high,    vt[v].exp_high);
      check({vt[v].name, "_period"},  last_period,  vt[v].exp_period);
      check({vt[v].name, "_timeout"}, last_timeout, 0);
      check({vt[v].name, "_level"},   last_level,   1);
    end

    // Line stuck low from reset release: one timeout on edge TIMEOUT+1.
    i_pwm     = 1'b0;
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    strobe_cnt = 0;
    i_reset_n  = 1'b1;
    repeat (512) @(posedge i_clk);
    #1 check("low_to_early_valid", int'(o_valid), 0);
    @(posedge i_clk);
    #1;
    check("low_to_valid",   int'(o_valid),   1);
    check("low_to_timeout", int'(o_timeout), 1);
    check("low_to_level",   int'(o_level),   0);
    check("low_to_high",    int'(o_high),    0);
    check("low_to_period",  int'(o_period),  0);
    repeat (2048) @(negedge i_clk);
    check("low_to_strobes", strobe_cnt, 1);

    // Stuck high after running at 0x80, then restart.
    do_reset();
    pulse(128, 256);
    pulse(128, 256);
    i_pwm = 1'b1;
    repeat (600) @(negedge i_clk);
    check("hi_to_strobes", strobe_cnt,   3);
    check("hi_to_timeout", last_timeout, 1);
    check("hi_to_level",   last_level,   1);
    check("hi_to_period",  last_period,  0);
    i_pwm = 1'b0;
    repeat (10) @(negedge i_clk);
    pulse(128, 256);
    check("restart_first_rise_quiet", strobe_cnt, 3);
    pulse(128, 256);
    pulse(128, 256);
    check("restart_strobes", strobe_cnt,   5);
    check("restart_timeout", last_timeout, 0);
    check("restart_high",    last_high,    128);
    check("restart_period",  last_period,  256);

    // Rise spacing 513 times out each gap; a 512 gap afterwards measures.
    do_reset();
    pulse(100, 513);
    pulse(100, 513);
    pulse(100, 513);
    pulse(100, 512);
    check("sp513_strobes", strobe_cnt,   3);
    check("sp513_timeout", last_timeout, 1);
    check("sp513_level",   last_level,   0);
    i_pwm = 1'b1;
    repeat (6) @(negedge i_clk);
    check("sp512_strobes", strobe_cnt,   4);
    check("sp512_timeout", last_timeout, 0);
    check("sp512_high",    last_high,    100);
    check("sp512_period",  last_period,  512);

    // Asynchronous reset pulse 20 cycles into a high phase.
    do_reset();
    pulse(64, 256);
    pulse(64, 256);
    i_pwm = 1'b1;
    repeat (20) @(negedge i_clk);
    @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    check("mid_rst_high",    int'(o_high),    0);
    check("mid_rst_period",  int'(o_period),  0);
    check("mid_rst_valid",   int'(o_valid),   0);
    check("mid_rst_timeout", int'(o_timeout), 0);
    check("mid_rst_level",   int'(o_level),   0);
    strobe_cnt = 0;
    #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    repeat (43) @(negedge i_clk);
    i_pwm = 1'b0;
    repeat (192) @(negedge i_clk);
    check("post_rst_first_rise_quiet", strobe_cnt, 0);
    // Synchronized line goes high 21 cycles into the phase after release,
    // so the first reported interval is 235 cycles with 43 high.
    pulse(64, 256);
    check("post_rst_2nd_strobes", strobe_cnt,   1);
    check("post_rst_2nd_high",    last_high,    43);
    check("post_rst_2nd_period",  last_period,  235);
    check("post_rst_2nd_timeout", last_timeout, 0);
    pulse(64, 256);
    check("post_rst_3rd_strobes", strobe_cnt,  2);
    check("post_rst_3rd_high",    last_high,   64);
    check("post_rst_3rd_period",  last_period, 256);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
